// File: rtl/ddr3_status_poller.sv
// Avalon-MM read master that polls the DDR3 controller status PIO after a start pulse
// and latches one sticky verdict: ready, failed or timeout.
module ddr3_status_poller #(
    parameter logic [1:0] STATUS_ADDR   = 2'd0,
    parameter int         READ_LATENCY  = 1,
    parameter int         POLL_INTERVAL = 1000,
    parameter int         MAX_POLLS     = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        ready,
    output logic        failed,
    output logic        timeout,
    output logic [2:0]  status,
    output logic [15:0] poll_count
);

    localparam int GW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_INTERVAL - 1);
    localparam logic [2:0]    LAT_LOAD = 3'(READ_LATENCY);
    localparam logic [15:0]   MAX_CNT  = 16'(MAX_POLLS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DATA = 3'd2,
        GAP       = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     lat_cnt, lat_nxt;
    logic [GW-1:0]  gap_cnt, gap_nxt;
    logic           ready_nxt, failed_nxt, timeout_nxt;
    logic [2:0]     status_nxt;
    logic [15:0]    count_nxt;
    logic           read_nxt, busy_nxt;

    // Only the three status bits carry meaning; the rest of the bus is dropped.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:3];

    always_comb begin
        state_nxt   = state;
        lat_nxt     = lat_cnt;
        gap_nxt     = gap_cnt;
        ready_nxt   = ready;
        failed_nxt  = failed;
        timeout_nxt = timeout;
        status_nxt  = status;
        count_nxt   = poll_count;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    ready_nxt   = 1'b0;
                    failed_nxt  = 1'b0;
                    timeout_nxt = 1'b0;
                    count_nxt   = 16'd0;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (!avm_waitrequest) begin
                    lat_nxt   = LAT_LOAD;
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (lat_cnt <= 3'd1) begin
                    status_nxt = avm_readdata[2:0];
                    count_nxt  = poll_count + 16'd1;
                    // cal_fail outranks a simultaneous init_done/cal_success pair.
                    if (avm_readdata[2]) begin
                        failed_nxt = 1'b1;
                        state_nxt  = DONE;
                    end else if (avm_readdata[1:0] == 2'b11) begin
                        ready_nxt = 1'b1;
                        state_nxt = DONE;
                    end else if (count_nxt == MAX_CNT) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = DONE;
                    end else begin
                        gap_nxt   = GAP_LOAD;
                        state_nxt = GAP;
                    end
                end else begin
                    lat_nxt = lat_cnt - 3'd1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = ISSUE;
                end else begin
                    gap_nxt = gap_cnt - GW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        read_nxt = (state_nxt == ISSUE);
        busy_nxt = (state_nxt == ISSUE) || (state_nxt == WAIT_DATA) || (state_nxt == GAP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            lat_cnt     <= 3'd0;
            gap_cnt     <= '0;
            avm_address <= STATUS_ADDR;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            failed      <= 1'b0;
            timeout     <= 1'b0;
            status      <= 3'd0;
            poll_count  <= 16'd0;
        end else begin
            state       <= state_nxt;
            lat_cnt     <= lat_nxt;
            gap_cnt     <= gap_nxt;
            avm_address <= STATUS_ADDR;
            avm_read    <= read_nxt;
            busy        <= busy_nxt;
            ready       <= ready_nxt;
            failed      <= failed_nxt;
            timeout     <= timeout_nxt;
            status      <= status_nxt;
            poll_count  <= count_nxt;
        end
    end

endmodule

// File: tb/tb_ddr3_status_poller.sv
// Bench for ddr3_status_poller: scripted status slave, hand-written vector table,
// randomized runs against a per-read arithmetic model, and multi-cycle corner cases.
module tb_ddr3_status_poller;

    localparam int         RL   = 1;
    localparam int         PI   = 4;
    localparam int         MP   = 5;
    localparam logic [1:0] ADDR = 2'd2;
    localparam int         W    = 46;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic [1:0]  avm_address;
    logic        avm_read, busy, ready, failed, timeout;
    logic [2:0]  status;
    logic [15:0] poll_count;

    always #5 clk = ~clk;

    ddr3_status_poller #(
        .STATUS_ADDR(ADDR), .READ_LATENCY(RL), .POLL_INTERVAL(PI), .MAX_POLLS(MP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(busy), .ready(ready), .failed(failed), .timeout(timeout),
        .status(status), .poll_count(poll_count)
    );

    int n_pass = 0;
    int n_total = 0;

    // Scripted slave: per-read response and wait-state count, indexed by read number.
    logic [2:0] cur_resp [8];
    int         cur_stalls [8];
    int         acc_idx = 0;
    int         rsp_idx = 0;
    int         lat_cd = 0;
    int         stall_left = 0;
    bit         in_read = 1'b0;

    // Expected record: {cycles[16], read_high_cycles[8], {ready,failed,timeout}, status, count[16]}
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [14:0] resp;
        int          stalls;
        logic [2:0]  flags;
        logic [2:0]  st;
        int          count;
        int          cycles;
        int          high;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Outside the data cycle the bus carries cal_fail garbage, so a mistimed capture shows up.
    always @(negedge clk) begin
        if (!reset_n) begin
            lat_cd          = 0;
            in_read         = 1'b0;
            avm_waitrequest = 1'b0;
            avm_readdata    = {29'($urandom), 3'b100};
        end else begin
            avm_readdata = {29'($urandom), 3'b100};
            if (lat_cd > 0) begin
                lat_cd--;
                if (lat_cd == 0) begin
                    avm_readdata = {29'($urandom), cur_resp[rsp_idx % 8]};
                    rsp_idx++;
                end
            end
            if (avm_read) begin
                if (!in_read) begin
                    in_read    = 1'b1;
                    stall_left = cur_stalls[acc_idx % 8];
                end
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    in_read         = 1'b0;
                    lat_cd          = RL;
                    acc_idx++;
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    // Walks the reads one by one using the verdict rules and period arithmetic.
    function automatic logic [W-1:0] model();
        int         cycles = 0;
        int         high = 0;
        int         n = 0;
        logic [2:0] flags = 3'b000;
        logic [2:0] st = 3'b000;
        for (int i = 0; i < MP; i++) begin
            n = i + 1;
            st = cur_resp[i];
            cycles += 1 + cur_stalls[i] + RL;
            high   += 1 + cur_stalls[i];
            if (st[2]) begin flags = 3'b010; break; end
            if (st[1:0] == 2'b11) begin flags = 3'b100; break; end
            if (n == MP) begin flags = 3'b001; break; end
            cycles += PI;
        end
        return {16'(cycles), 8'(high), flags, st, 16'(n)};
    endfunction

    task automatic load_vec(input int k);
        for (int i = 0; i < 5; i++) begin
            cur_resp[i]   = vecs[k].resp[3*i +: 3];
            cur_stalls[i] = vecs[k].stalls;
        end
    endtask

    task automatic run_seq(input string tag, input int inject_at,
                           output int cyc, output int bursts, output int high);
        bit prev;
        acc_idx = 0;
        rsp_idx = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0; bursts = 0; high = 0; prev = 1'b0;
        check({tag, ".busy_at_start"}, busy, 1);
        check({tag, ".flags_cleared"}, {ready, failed, timeout}, 0);
        check({tag, ".count_cleared"}, poll_count, 0);
        while (busy && cyc < 400) begin
            if (avm_read) begin
                high++;
                if (!prev) bursts++;
            end
            prev = avm_read;
            if (cyc == inject_at) start = 1'b1;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic finish_run(input string tag, input int cyc, input int bursts, input int high);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check({tag, ".busy_done"},  busy, 0);
        check({tag, ".ready"},      ready, int'(e[21]));
        check({tag, ".failed"},     failed, int'(e[20]));
        check({tag, ".timeout"},    timeout, int'(e[19]));
        check({tag, ".status"},     status, int'(e[18:16]));
        check({tag, ".poll_count"}, poll_count, int'(e[15:0]));
        check({tag, ".cycles"},     cyc, int'(e[45:30]));
        check({tag, ".read_high"},  high, int'(e[29:22]));
        check({tag, ".bursts"},     bursts, int'(e[15:0]));
        check({tag, ".accepted"},   acc_idx, int'(e[15:0]));
        check({tag, ".address"},    avm_address, ADDR);
    endtask

    task automatic push_vec(input int k);
        exp_q.push_back({16'(vecs[k].cycles), 8'(vecs[k].high), vecs[k].flags,
                         vecs[k].st, 16'(vecs[k].count)});
    endtask

    initial begin
        int cyc, bursts, high, viol;

        //               resp {r4,r3,r2,r1,r0}    stl flags   status  n  cyc hi
        vecs[0] = '{15'b000_000_000_000_011, 0, 3'b100, 3'b011, 1,  2,  1};
        vecs[1] = '{15'b000_011_001_001_001, 2, 3'b100, 3'b011, 4, 28, 12};
        vecs[2] = '{15'b000_000_000_000_111, 0, 3'b010, 3'b111, 1,  2,  1};
        vecs[3] = '{15'b000_000_000_000_000, 0, 3'b001, 3'b000, 5, 26,  5};
        vecs[4] = '{15'b000_000_000_101_001, 1, 3'b010, 3'b101, 2, 10,  4};
        vecs[5] = '{15'b001_000_010_001_010, 0, 3'b001, 3'b001, 5, 26,  5};
        vecs[6] = '{15'b000_000_000_000_110, 1, 3'b010, 3'b110, 1,  3,  2};
        vecs[7] = '{15'b000_000_000_011_010, 0, 3'b100, 3'b011, 2,  8,  2};

        // Clock/reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.outputs", {avm_read, busy, ready, failed, timeout, status, poll_count}, 0);
        check("reset.address", avm_address, ADDR);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle.no_read", avm_read | busy, 0);

        // Vector table
        for (int k = 0; k < 8; k++) begin
            load_vec(k);
            push_vec(k);
            run_seq($sformatf("vec%0d", k), -1, cyc, bursts, high);
            finish_run($sformatf("vec%0d", k), cyc, bursts, high);
        end

        // start pulsed mid-run, then in the cycle the run completes, then restart after DONE
        load_vec(3);
        push_vec(3);
        run_seq("busy_start", 3, cyc, bursts, high);
        finish_run("busy_start", cyc, bursts, high);
        push_vec(3);
        run_seq("start_at_done", vecs[3].cycles - 1, cyc, bursts, high);
        finish_run("start_at_done", cyc, bursts, high);
        @(posedge clk);
        @(negedge clk);
        check("start_at_done.idle", busy, 0);
        check("start_at_done.hold", timeout, 1);
        load_vec(0);
        push_vec(0);
        run_seq("restart", -1, cyc, bursts, high);
        finish_run("restart", cyc, bursts, high);

        // Randomized runs against the model
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 8; i++) begin
                cur_resp[i]   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                             : 3'($urandom_range(0, 2));
                cur_stalls[i] = $urandom_range(0, 2);
            end
            exp_q.push_back(model());
            run_seq($sformatf("rand%0d", r), -1, cyc, bursts, high);
            finish_run($sformatf("rand%0d", r), cyc, bursts, high);
        end

        // Reset during WAIT_DATA of the third read
        for (int i = 0; i < 8; i++) begin
            cur_resp[i]   = 3'b001;
            cur_stalls[i] = 0;
        end
        acc_idx = 0;
        rsp_idx = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        check("mid_reset.pre_count", poll_count, 2);
        check("mid_reset.pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_reset.outputs", {avm_read, busy, ready, failed, timeout, status, poll_count}, 0);
        check("mid_reset.address", avm_address, ADDR);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        viol = 0;
        repeat (12) begin
            @(negedge clk);
            if (avm_read || busy || poll_count != 16'd0) viol++;
        end
        check("mid_reset.stays_idle", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
